// File: rtl/frequency_counter_if.sv
// Display-side bundle of frequency_counter: measured input plus the BCD result
// and its load strobe, wired straight into the seven-segment driver.
interface frequency_counter_if;
   logic       signal;
   logic [3:0] ten_count;
   logic [3:0] unit_count;
   logic       load;

   // load is a valid-only strobe with no ready: the consumer must take
   // ten_count/unit_count in the single cycle load is high; both digits then
   // hold until the next load.
   modport master (input signal, output ten_count, output unit_count, output load);
   modport slave  (output signal, input ten_count, input unit_count, input load);
endinterface

// File: rtl/frequency_counter.sv
// Counts rising edges of bus.signal over UPDATE_PERIOD clocks, then converts to two BCD
// digits with a one-cycle load. Optional macro SYNC_INPUT_EN adds a two-flop synchronizer.
module frequency_counter #(
   parameter int UPDATE_PERIOD = 1200
) (
   input  logic                 clk,
   input  logic                 reset,
   frequency_counter_if.master  bus,
   output logic [1:0]           state_dbg,
   output logic [6:0]           edge_dbg
);

   localparam logic [1:0]  COUNT = 2'd0;
   localparam logic [1:0]  TENS  = 2'd1;
   localparam logic [1:0]  UNITS = 2'd2;
   localparam logic [15:0] LAST  = 16'(UPDATE_PERIOD - 1);
   localparam logic [6:0]  SAT   = 7'd99;

   logic [1:0]  state;
   logic [15:0] clk_cnt;
   logic [6:0]  edge_cnt;
   logic [3:0]  tens_acc;
   logic [3:0]  ten_q;
   logic [3:0]  unit_q;
   logic        load_q;
   logic        s_q;
   logic        p_q;
   logic        rise;

`ifdef SYNC_INPUT_EN
   logic meta_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         s_q    <= 1'b0;
      end else begin
         meta_q <= bus.signal;
         s_q    <= meta_q;
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) s_q <= 1'b0;
      else        s_q <= bus.signal;
   end
`endif

   // p_q keeps sampling through the dead time so a boundary edge is seen only once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) p_q <= 1'b0;
      else        p_q <= s_q;
   end

   assign rise = s_q & ~p_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= COUNT;
         clk_cnt  <= '0;
         edge_cnt <= '0;
         tens_acc <= '0;
         ten_q    <= '0;
         unit_q   <= '0;
         load_q   <= 1'b0;
      end else begin
         load_q <= 1'b0;
         case (state)
            COUNT: begin
               if (rise && edge_cnt != SAT) edge_cnt <= edge_cnt + 7'd1;
               if (clk_cnt == LAST) begin
                  clk_cnt <= '0;
                  state   <= TENS;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            TENS: begin
               // Repeated subtraction: one tens digit per cycle.
               if (edge_cnt >= 7'd10) begin
                  edge_cnt <= edge_cnt - 7'd10;
                  tens_acc <= tens_acc + 4'd1;
               end else begin
                  state <= UNITS;
               end
            end
            UNITS: begin
               ten_q    <= tens_acc;
               unit_q   <= edge_cnt[3:0];
               load_q   <= 1'b1;
               edge_cnt <= '0;
               tens_acc <= '0;
               state    <= COUNT;
            end
            default: state <= COUNT;
         endcase
      end
   end

   assign bus.ten_count  = ten_q;
   assign bus.unit_count = unit_q;
   assign bus.load       = load_q;
   assign state_dbg      = state;
   assign edge_dbg       = edge_cnt;

endmodule
